// File: rtl/quat_mul_sequencer_if.sv
// +-----------------------------------------------------------------------+
// | quat_mul_sequencer_if : operand/result handshake bundle for the         |
// | resource-shared quaternion multiplier (ovf present with QMUL_OVF_EN).   |
// | Revision: 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

interface quat_mul_sequencer_if #(
   parameter int DW = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic signed [DW-1:0]   a1, b1, c1, d1;
   logic signed [DW-1:0]   a2, b2, c2, d2;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [2*DW-1:0] r1, r2, r3, r4;
   logic                   busy;
`ifdef QMUL_OVF_EN
   logic [3:0]             ovf;
`endif

   modport master (
`ifdef QMUL_OVF_EN
      input  ovf,
`endif
      output in_valid, a1, b1, c1, d1, a2, b2, c2, d2, out_ready,
      input  in_ready, out_valid, r1, r2, r3, r4, busy
   );

   modport slave (
`ifdef QMUL_OVF_EN
      output ovf,
`endif
      input  in_valid, a1, b1, c1, d1, a2, b2, c2, d2, out_ready,
      output in_ready, out_valid, r1, r2, r3, r4, busy
   );
endinterface

`default_nettype wire

// File: rtl/quat_mul_sequencer.sv
// +-----------------------------------------------------------------------+
// | quat_mul_sequencer : Hamilton product q1*q2 on one DW x DW multiplier,  |
// | 16 MAC cycles. Optional QMUL_OVF_EN adds per-component overflow flags.  |
// | Revision: 1.0                                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module quat_mul_sequencer #(
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   quat_mul_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int c_AW = 2*DW + 2;
   // Terms subtracted in the schedule: cnt 1,2,3,7,9,14
   localparam logic [15:0] c_NEG_MASK = 16'h428E;

   state_t                 r_state;
   logic [3:0]             r_cnt;
   logic signed [c_AW-1:0] r_acc;
   logic signed [DW-1:0]   r_q1 [4];
   logic signed [DW-1:0]   r_q2 [4];
   logic signed [2*DW-1:0] r_res [4];
   logic                   r_in_ready;
   logic                   r_out_valid;
   logic                   r_busy;
`ifdef QMUL_OVF_EN
   logic [3:0]             r_ovf;
`endif

   logic signed [DW-1:0]   w_x, w_y;
   logic signed [2*DW-1:0] w_xe, w_ye, w_prod;
   logic signed [c_AW-1:0] w_prod_ext, w_term, w_sum;

   // x walks a,b,c,d; y is the same walk permuted by the component index
   assign w_x        = r_q1[r_cnt[1:0]];
   assign w_y        = r_q2[r_cnt[1:0] ^ r_cnt[3:2]];
   assign w_xe       = {{DW{w_x[DW-1]}}, w_x};
   assign w_ye       = {{DW{w_y[DW-1]}}, w_y};
   assign w_prod     = w_xe * w_ye;
   assign w_prod_ext = {{2{w_prod[2*DW-1]}}, w_prod};
   assign w_term     = c_NEG_MASK[r_cnt] ? -w_prod_ext : w_prod_ext;
   assign w_sum      = r_acc + w_term;

`ifdef QMUL_OVF_EN
   logic w_ovf;
   assign w_ovf = (w_sum[c_AW-1:2*DW-1] != 3'b000) && (w_sum[c_AW-1:2*DW-1] != 3'b111);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_acc       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_q1[i]  <= '0;
            r_q2[i]  <= '0;
            r_res[i] <= '0;
         end
`ifdef QMUL_OVF_EN
         r_ovf       <= 4'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_q1[0]    <= bus.a1;
                  r_q1[1]    <= bus.b1;
                  r_q1[2]    <= bus.c1;
                  r_q1[3]    <= bus.d1;
                  r_q2[0]    <= bus.a2;
                  r_q2[1]    <= bus.b2;
                  r_q2[2]    <= bus.c2;
                  r_q2[3]    <= bus.d2;
                  r_cnt      <= 4'd0;
                  r_acc      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_MAC;
`ifdef QMUL_OVF_EN
                  r_ovf      <= 4'd0;
`endif
               end
            end
            S_MAC: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt[1:0] == 2'd3) begin
                  r_res[r_cnt[3:2]] <= w_sum[2*DW-1:0];
                  r_acc             <= '0;
`ifdef QMUL_OVF_EN
                  r_ovf[r_cnt[3:2]] <= w_ovf;
`endif
                  if (r_cnt == 4'd15) begin
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end else begin
                  r_acc <= w_sum;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.r1        = r_res[0];
   assign bus.r2        = r_res[1];
   assign bus.r3        = r_res[2];
   assign bus.r4        = r_res[3];
`ifdef QMUL_OVF_EN
   assign bus.ovf       = r_ovf;
`endif

endmodule

`default_nettype wire

// File: doc/quat_mul_sequencer.md
Name: quat_mul_sequencer

Overview:
Resource-shared quaternion multiplier. It computes the Hamilton product of two signed quaternions using a single signed DW x DW multiplier and one accumulator, sequenced over 16 cycles. It is the area-reduced counterpart of the combinational quaternion multiply path, with a valid/ready handshake on both input and output so it can sit between pipelined stages.

Parameters:
DW, 16, signed operand width; results are 2*DW bits wide, with a (2*DW+2)-bit internal accumulator.

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand set valid
in_ready  out  1  block can accept operands (high only in IDLE)
a1,b1,c1,d1  in  DW each  signed quaternion q1 = a1 + b1 i + c1 j + d1 k
a2,b2,c2,d2  in  DW each  signed quaternion q2
out_valid  out  1  r1..r4 hold a valid result
out_ready  in  1  downstream accepts result
r1,r2,r3,r4  out  2*DW each  signed components of q1*q2
busy  out  1  high in MAC or DONE

Behaviour:
- Reset (async, any state, including mid-computation): state=IDLE, cnt=0, acc=0, r1..r4=0, out_valid=0, busy=0, in_ready=1 once reset is released. An in-flight operation is discarded.
- States: IDLE -> MAC -> DONE -> IDLE.
- IDLE: in_ready=1. Edge with in_valid&&in_ready: latch all 8 operands, cnt=0, acc=0, go to MAC. Operand inputs are ignored after latching.
- MAC: in_ready=0. Each edge does acc += sign(cnt) * (x(cnt)*y(cnt)), using a full 2*DW-bit signed product sign-extended into the accumulator. cnt increments 0..15.
- Term schedule (cnt: x*y, sign):
  - r1: 0 a1a2 +, 1 b1b2 -, 2 c1c2 -, 3 d1d2 -
  - r2: 4 a1b2 +, 5 b1a2 +, 6 c1d2 +, 7 d1c2 -
  - r3: 8 a1c2 +, 9 b1d2 -, 10 c1a2 +, 11 d1b2 +
  - r4: 12 a1d2 +, 13 b1c2 +, 14 c1b2 -, 15 d1a2 +
- Component commit: on the edge where cnt[1:0]==3, the final sum (acc plus this term) is written to the component register, truncated to the low 2*DW bits (two's-complement wrap), and acc clears to 0.
  - r1..r4 change only at these commit edges. r4 commits on the cnt==15 edge, which also moves the state to DONE.
- Latency: operands are accepted at edge E0; out_valid=1 after edge E16 (16 cycles). With out_ready held high, the result handshake occurs at E17 and in_ready=1 after E17. Minimum initiation interval is 18 cycles, because no accept happens in the same cycle as the result handshake.
- DONE: out_valid=1, r1..r4 stable. Held indefinitely until out_ready=1. At the edge with out_valid&&out_ready: out_valid=0, go to IDLE. r1..r4 keep their values until overwritten by the next commits.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

Optional Feature:
Macro QMUL_OVF_EN.
- Defined: adds output port ovf [3:0], registered. Bit k is set at component k's commit when the exact (2*DW+2)-bit sum falls outside the signed 2*DW range. ovf is cleared at acceptance (E0) and at reset, and is valid while out_valid=1. r values still wrap.
- Undefined: no ovf port, no overflow logic; wrap behaviour is identical.

Test Plan:
- Identity left: q1=(1,0,0,0), q2=(2,3,4,5) -> r=(2,3,4,5); out_valid rises exactly 16 cycles after the accept edge.
- Negative operands: q1=(-1,-2,-3,-4), q2=(4,3,2,1) -> r=(12,-6,-24,-12).
- Large magnitude: q1=(30000,20000,-15000,10000), q2=(-10000,15000,-20000,30000) -> r1=-1200000000; remaining components checked against a reference model; no ovf bits set.
- Wrap: all eight operands -32768 -> r1=0x80000000 (exact -2^31), r2=0x80000000 (2^31 wrapped), r3=r4=0x80000000 (2^31 wrapped); with QMUL_OVF_EN, ovf=4'b1110.
- Backpressure and handshake: hold out_ready=0 for 10 cycles in DONE -> r stable, out_valid=1, in_ready=0, and a new in_valid is not accepted; release out_ready -> one handshake, then a back-to-back second operation runs at an 18-cycle interval.
- Reset mid-op: assert rst at cnt=7 -> outputs are immediately 0 and out_valid=0; after release, a fresh operation gives the correct result.
